cnn_conv1_acc: RTL and testbench

Accumulation stage of the conv1 datapath, directly downstream of the 10×14 signed multiplier. It consumes the stream of 25-bit signed products for one output pixel (one kernel window, TAPS products) and sums them in a wide accumulator. It adds the channel bias, rescales by an arithmetic right shift with rounding, and saturates to the activation width. Each finished pixel is presented on a valid/ready output port to the next layer's buffer.

---
 rtl/cnn_conv1_acc.sv | 123 ++++++++++++
 tb/tb_cnn_conv1_acc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_conv1_acc.sv
// cnn_conv1_acc: conv1 accumulation stage. Sums TAPS signed products per
// output pixel, adds the channel bias, rescales by SHIFT with round-half-up,
// saturates to OUT_W and offers the pixel on a valid/ready port.
// Optional feature: define CNN_CONV1_RELU_EN to clamp negative results to 0.
module cnn_conv1_acc #(
    parameter int PROD_W = 25,
    parameter int ACC_W  = 32,
    parameter int TAPS   = 25,
    parameter int BIAS_W = 14,
    parameter int SHIFT  = 8,
    parameter int OUT_W  = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [PROD_W-1:0] prod_data,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [BIAS_W-1:0] bias,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat_flag
);

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] OMAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {ACC, OUT} state_t;

    state_t                    state, state_nx;
    logic [CNT_W-1:0]          cnt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   bias_q;

    logic                      accept;
    logic                      last_tap;
    logic signed [ACC_W-1:0]   prod_sx;
    logic signed [ACC_W-1:0]   bias_sh;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   rnd;
    logic signed [ACC_W-1:0]   shifted;
    logic                      sat_hi;
    logic                      sat_lo;
    logic signed [OUT_W-1:0]   res;

    // State register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)
            state <= ACC;
        else
            state <= state_nx;
    end

    // Next state and handshake; prod_ready depends only on state and reset.
    always_comb begin
        state_nx   = state;
        prod_ready = (state == ACC) & ~ap_rst;
        accept     = prod_valid & prod_ready;
        last_tap   = accept & (cnt == LAST);
        case (state)
            ACC: if (last_tap)  state_nx = OUT;
            OUT: if (out_ready) state_nx = ACC;
            default:            state_nx = ACC;
        endcase
    end

    // Final-tap arithmetic: bias add, rounded rescale and saturation.
    always_comb begin
        prod_sx = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
        bias_sh = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias} << SHIFT;
        sum     = acc + prod_sx + bias_q;
        rnd     = sum + HALF;
        shifted = rnd >>> SHIFT;
        sat_hi  = shifted > OMAX;
        sat_lo  = shifted < OMIN;
        if (sat_hi)
            res = OMAX[OUT_W-1:0];
        else if (sat_lo)
            res = OMIN[OUT_W-1:0];
        else
            res = shifted[OUT_W-1:0];
`ifdef CNN_CONV1_RELU_EN
        if (res[OUT_W-1])
            res = '0;
`endif
    end

    // Tap counter, accumulator, bias capture and output register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt       <= '0;
            acc       <= '0;
            bias_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
                if (cnt == '0) begin
                    acc    <= prod_sx;
                    bias_q <= bias_sh;
                end else begin
                    acc <= acc + prod_sx;
                end
            end
            if (last_tap) begin
                out_data  <= res;
                out_valid <= 1'b1;
                if (sat_hi | sat_lo)
                    sat_flag <= 1'b1;
            end else if (state == OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cnn_conv1_acc.sv
// tb_cnn_conv1_acc: scoreboard bench for cnn_conv1_acc with default parameters.
// Expected pixels are computed from the driven taps and popped at each output
// handshake. Build with CNN_CONV1_RELU_EN to check the ReLU variant.
module tb_cnn_conv1_acc;

    localparam int PROD_W = 25;
    localparam int BIAS_W = 14;
    localparam int OUT_W  = 16;
    localparam int TAPS   = 25;
    localparam int SHIFT  = 8;

    typedef struct {
        longint data;
        bit     sat;
    } exp_t;

    logic                     ap_clk = 1'b0;
    logic                     ap_rst;
    logic signed [PROD_W-1:0] prod_data;
    logic                     prod_valid;
    logic                     prod_ready;
    logic signed [BIAS_W-1:0] bias;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     sat_flag;

    exp_t exp_q[$];
    bit   exp_sat;
    int   n_checks;
    int   n_fail;

    cnn_conv1_acc #(
        .PROD_W(PROD_W),
        .ACC_W (32),
        .TAPS  (TAPS),
        .BIAS_W(BIAS_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .prod_data (prod_data),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .bias      (bias),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference result for one window.
    task automatic push_expected(input longint sum, input int b);
        longint s, r;
        bit     sat;
        exp_t   e;
        s   = sum + longint'(b) * (longint'(1) << SHIFT);
        r   = (s + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        sat = 1'b0;
        if (r > 32767) begin
            r   = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r   = -32768;
            sat = 1'b1;
        end
`ifdef CNN_CONV1_RELU_EN
        if (r < 0) r = 0;
`endif
        exp_sat = exp_sat | sat;
        e.data  = r;
        e.sat   = exp_sat;
        exp_q.push_back(e);
    endtask

    // Drive ntaps products (tap0 = v0, others vr); a full window is scored.
    task automatic send_window(input int ntaps, input int v0, input int vr, input int b);
        longint sum;
        int     budget;
        int     v;
        sum = 0;
        for (int i = 0; i < ntaps; i++) begin
            v          = (i == 0) ? v0 : vr;
            prod_data  = PROD_W'(v);
            bias       = BIAS_W'(b);
            prod_valid = 1'b1;
            budget     = 0;
            @(negedge ap_clk);
            while (!prod_ready && budget < 200) begin
                @(negedge ap_clk);
                budget++;
            end
            if (budget >= 200)
                check_eq("accept_timeout", budget, 0);
            @(posedge ap_clk);
            #1;
            sum += v;
            if (i == TAPS - 1) begin
                push_expected(sum, b);
                check_eq("latency_valid", out_valid, 1);
            end
        end
        prod_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (out_valid && budget < 100) begin
            @(posedge ap_clk);
            #1;
            budget++;
        end
        if (budget >= 100)
            check_eq("idle_timeout", budget, 0);
    endtask

    // Scoreboard: compare at every output handshake.
    always @(negedge ap_clk) begin
        exp_t e;
        if (!ap_rst && out_valid && out_ready) begin
            check_eq("sb_has_entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("out_data", out_data, e.data);
                check_eq("sat_flag", sat_flag, e.sat);
            end
        end
    end

    initial begin
        int     budget;
        longint held;
        n_checks   = 0;
        n_fail     = 0;
        exp_sat    = 1'b0;
        ap_rst     = 1'b1;
        prod_valid = 1'b0;
        prod_data  = '0;
        bias       = '0;
        out_ready  = 1'b1;

        repeat (3) @(negedge ap_clk);
        check_eq("rst_prod_ready", prod_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_sat_flag", sat_flag, 0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check_eq("post_rst_prod_ready", prod_ready, 1);
        @(posedge ap_clk);
        #1;

        send_window(TAPS, 256, 256, 0);
        send_window(TAPS, 384, 0, 0);
        send_window(TAPS, -384, 0, 0);
        send_window(TAPS, 0, 0, 10);
        send_window(TAPS, 1000, -3, -8192);
        send_window(TAPS, 8388607, 8388607, 0);
        send_window(TAPS, -8388608, -8388608, 0);
        send_window(TAPS, 256, 256, 0);
        wait_idle();
        check_eq("sat_sticky", sat_flag, 1);

        // Backpressure: two back-to-back windows, consumer stalls the first.
        out_ready = 1'b0;
        fork
            begin
                send_window(TAPS, 100, 100, 3);
                send_window(TAPS, -1000, 7, -5);
            end
            begin
                budget = 0;
                while (!out_valid && budget < 200) begin
                    @(posedge ap_clk);
                    #1;
                    budget++;
                end
                if (budget >= 200)
                    check_eq("bp_valid_timeout", budget, 0);
                held = out_data;
                repeat (5) begin
                    @(negedge ap_clk);
                    check_eq("bp_prod_ready", prod_ready, 0);
                    check_eq("bp_out_valid", out_valid, 1);
                    check_eq("bp_out_data_stable", out_data, held);
                    @(posedge ap_clk);
                    #1;
                end
                out_ready = 1'b1;
                @(posedge ap_clk);
                #1;
                check_eq("bp_valid_dropped", out_valid, 0);
                @(negedge ap_clk);
                check_eq("bp_next_accept_ready", prod_ready, 1);
                check_eq("bp_next_accept_valid", prod_valid, 1);
            end
        join
        wait_idle();

        // Reset mid-window: the 12 partial taps must leave no trace.
        send_window(12, 1000, 1000, 50);
        ap_rst  = 1'b1;
        exp_sat = 1'b0;
        @(negedge ap_clk);
        check_eq("midrst_prod_ready", prod_ready, 0);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_out_data", out_data, 0);
        check_eq("midrst_sat_flag", sat_flag, 0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        send_window(TAPS, 256, 256, 0);
        wait_idle();

        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            @(posedge ap_clk);
            budget++;
        end
        check_eq("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
